// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit carry-look-ahead adder/subtractor. The add is
// split into N = WIDTH/GROUP look-ahead groups with one register stage each. It
// sustains one operation per clock. A valid/ready handshake on each side
// applies a global stall.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   a, b, cin, sub      operands; sub=1 computes a - b - cin
//   out_valid/out_ready result handshake
//   sum, carry, ovf     registered result, carry-out (no-borrow in subtract
//                       mode) and two's-complement signed overflow
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned N = WIDTH / GROUP;

  if ((GROUP == 0) || ((WIDTH % GROUP) != 0)) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of GROUP");
  end

  // One look-ahead group: returns {carry_out, sum[GROUP-1:0]}. Every carry is
  // formed from the group-prefix generate/propagate and the group carry-in.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] x,
                                               input logic [GROUP-1:0] y,
                                               input logic             ci);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             gg;
    logic             pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    gg   = 1'b0;
    pp   = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      gg       = g[i] | (p[i] & gg);
      pp       = pp & p[i];
      c[i+1]   = gg | (pp & ci);
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  logic             advance_c;
  logic [WIDTH-1:0] b_eff_c;
  logic             c0_c;

  // Global stall: every stage moves only when the output slot is free or draining.
  always_comb begin
    advance_c = !out_valid || out_ready;
    in_ready  = advance_c;
  end

  // Subtraction as a + ~b + !cin.
  always_comb begin
    b_eff_c = sub ? ~b : b;
    c0_c    = sub ? ~cin : cin;
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int unsigned SW = (k + 1) * GROUP;  // sum bits resolved so far
    localparam int unsigned OW = WIDTH - SW;       // operand bits still pending

    logic [GROUP-1:0] a_g;
    logic [GROUP-1:0] b_g;
    logic             ci_g;
    logic [GROUP:0]   res_c;
    logic [SW-1:0]    sum_d, sum_q;
    logic             c_d, c_q;
    logic             v_d, v_q;

    assign res_c = cla_group(a_g, b_g, ci_g);

    if (k == 0) begin : g_head
      always_comb begin
        a_g   = a[GROUP-1:0];
        b_g   = b_eff_c[GROUP-1:0];
        ci_g  = c0_c;
        v_d   = in_valid;
        sum_d = res_c[GROUP-1:0];
        c_d   = res_c[GROUP];
      end
    end else begin : g_body
      always_comb begin
        a_g   = g_stage[k-1].g_ops.a_q[GROUP-1:0];
        b_g   = g_stage[k-1].g_ops.b_q[GROUP-1:0];
        ci_g  = g_stage[k-1].c_q;
        v_d   = g_stage[k-1].v_q;
        sum_d = {res_c[GROUP-1:0], g_stage[k-1].sum_q};
        c_d   = res_c[GROUP];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance_c) begin
        v_q   <= v_d;
        c_q   <= c_d;
        sum_q <= sum_d;
      end
    end

    // Upper operand bits not yet consumed, shrinking by one group per stage.
    if (OW > 0) begin : g_ops
      logic [OW-1:0] a_d, a_q;
      logic [OW-1:0] b_d, b_q;

      if (k == 0) begin : g_src_in
        always_comb begin
          a_d = a[WIDTH-1:GROUP];
          b_d = b_eff_c[WIDTH-1:GROUP];
        end
      end else begin : g_src_prev
        always_comb begin
          a_d = g_stage[k-1].g_ops.a_q[OW+GROUP-1:GROUP];
          b_d = g_stage[k-1].g_ops.b_q[OW+GROUP-1:GROUP];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance_c) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // Carry into the MSB is recovered as sum_msb ^ a_msb ^ b_msb.
    if (k == N - 1) begin : g_tail
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = res_c[GROUP] ^ res_c[GROUP-1] ^ a_g[GROUP-1] ^ b_g[GROUP-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance_c) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[N-1].v_q;
  assign sum       = g_stage[N-1].sum_q;
  assign carry     = g_stage[N-1].c_q;
  assign ovf       = g_stage[N-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed testbench for pipelined_cla_adder (WIDTH=16, GROUP=4, 4 stages).
module tb_pipelined_cla_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned GROUP = 4;
  localparam int          NOPS  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] sa [NOPS];
  logic [15:0] sbv[NOPS];
  logic        sci[NOPS];
  logic        ssb[NOPS];
  logic [17:0] exp_q[$];
  logic [17:0] head;
  int          sent;
  int          popped;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 17-bit arithmetic, returns {ovf, carry, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [15:0] ye;
    logic [16:0] r;
    logic        cc;
    ye = sb ? ~y : y;
    cc = sb ? ~ci : ci;
    r  = {1'b0, x} + {1'b0, ye} + {16'd0, cc};
    return {(x[15] == ye[15]) && (r[15] != x[15]), r[16], r[15:0]};
  endfunction

  // Single operation into an empty pipeline; result expected after edge E0+3.
  task automatic send_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic eo);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, "_early_valid"}, 32'(out_valid), 32'(0));
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_sum"},   32'(sum),       32'(es));
    check({tag, "_carry"}, 32'(carry),     32'(ec));
    check({tag, "_ovf"},   32'(ovf),       32'(eo));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum",       32'(sum),       32'(0));
    check("rst_in_ready",  32'(in_ready),  32'(1));
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'(1));

    // Directed add / subtract vectors
    send_one("add_ff_1",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    send_one("add_wrap",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_one("add_grp",    16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    send_one("add_negneg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    send_one("add_all1",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    send_one("sub_5_7",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_one("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_one("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
    send_one("sub_zero",   16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    tick();
    check("drain_idle", 32'(out_valid), 32'(0));

    // Streaming with a 3-cycle stall while full
    for (int i = 0; i < NOPS; i++) begin
      sa[i]  = 16'($urandom);
      sbv[i] = 16'($urandom);
      sci[i] = 1'($urandom_range(0, 1));
      ssb[i] = 1'($urandom_range(0, 1));
    end
    sent = 0;
    popped = 0;
    for (int c = 0; c < 60 && (sent < NOPS || exp_q.size() != 0); c++) begin
      out_ready = !(c >= 12 && c < 15);
      in_valid  = (sent < NOPS);
      if (sent < NOPS) begin
        a = sa[sent]; b = sbv[sent]; cin = sci[sent]; sub = ssb[sent];
      end
      #1;
      if (c >= 1 && c <= 11) check("stream_valid_timing", 32'(out_valid), 32'(c >= 4));
      if (!out_ready) begin
        check("bp_in_ready",  32'(in_ready),  32'(0));
        check("bp_out_valid", 32'(out_valid), 32'(1));
        if (exp_q.size() != 0) begin
          head = exp_q[0];
          check("bp_hold", 32'({ovf, carry, sum}), 32'(head));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 32'(out_valid), 32'(0));
        end else begin
          head = exp_q.pop_front();
          check("stream_result", 32'({ovf, carry, sum}), 32'(head));
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stream_sent",   32'(sent),   32'(NOPS));
    check("stream_popped", 32'(popped), 32'(NOPS));
    check("stream_idle",   32'(out_valid), 32'(0));

    // Reset mid-stream: result parked at the output, three more in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 16'h9000 : 16'(i);
      b = (i == 0) ? 16'h9000 : 16'(i + 1);
      cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_valid",  32'(out_valid), 32'(1));
    check("pre_rst_result", 32'({ovf, carry, sum}), 32'({1'b1, 1'b1, 16'h2000}));
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid",    32'(out_valid), 32'(0));
    check("async_rst_sum",      32'(sum),       32'(0));
    check("async_rst_carry",    32'(carry),     32'(0));
    check("async_rst_ovf",      32'(ovf),       32'(0));
    check("async_rst_in_ready", 32'(in_ready),  32'(1));
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_stale", 32'(out_valid), 32'(0));
    end
    send_one("post_rst_first", 16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0);
    tick();
    check("final_idle", 32'(out_valid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
